hazard_sched: RTL

Pipeline hazard scheduler for the five-stage RISC-V core. It watches the decode stage, the execute stage and the data-memory port, and sequences the core's stall and flush controls:
- `hazard` and `flush` feed the execute stage.
- `pc_stall` and `if_id_stall` feed fetch and decode.

It serialises load-use bubbles, taken-branch/jump squashes, multi-cycle memory waits and an optional FPGA debug halt/single-step.

---
 rtl/hazard_sched_if.sv | 34 +++
 rtl/hazard_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched_if.sv
// rtl/hazard_sched_if.sv - decode/execute/memory hazard inputs and stall/flush controls of hazard_sched
interface hazard_sched_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 id_valid;
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic                 ex_mem_read;
    logic [4:0]           ex_rd;
    logic                 ex_pc_write;
    logic                 mem_busy;
    logic                 dbg_halt;
    logic                 dbg_step;
    logic                 pc_stall;
    logic                 if_id_stall;
    logic                 hazard;
    logic                 flush;
    logic                 halted;
    logic [CNT_WIDTH-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_mem_read, ex_rd, ex_pc_write, mem_busy, dbg_halt, dbg_step,
        input  pc_stall, if_id_stall, hazard, flush, halted, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_mem_read, ex_rd, ex_pc_write, mem_busy, dbg_halt, dbg_step,
        output pc_stall, if_id_stall, hazard, flush, halted, stall_count
    );
endinterface

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - pipeline stall/flush sequencer; HAZARD_DEBUG_STEP_EN adds debug halt/single-step
module hazard_sched #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_sched_if.slave hs
);
    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_MEM_WAIT = 3'd1,
        S_FLUSH    = 3'd2,
        S_HALT     = 3'd3,
        S_STEP     = 3'd4
    } state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t               state_q, state_d;
    logic [1:0]           fcnt_q, fcnt_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic                 lu;
    logic                 stall_c;
    logic                 flush_c;
    logic                 pc_stall_o;

`ifdef HAZARD_DEBUG_STEP_EN
    logic ret_halt_q, ret_halt_d;
    logic halted_c;
`else
    logic unused_dbg;
    assign unused_dbg = hs.dbg_halt ^ hs.dbg_step;
`endif

    assign lu = hs.ex_mem_read && (hs.ex_rd != 5'd0) && hs.id_valid &&
                ((hs.id_rs1_used && (hs.id_rs1 == hs.ex_rd)) ||
                 (hs.id_rs2_used && (hs.id_rs2 == hs.ex_rd)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_RUN;
            fcnt_q        <= 2'd0;
            stall_count_q <= '0;
`ifdef HAZARD_DEBUG_STEP_EN
            ret_halt_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            stall_count_q <= stall_count_d;
`ifdef HAZARD_DEBUG_STEP_EN
            ret_halt_q    <= ret_halt_d;
`endif
        end
    end

    // RUN and the exit cycle of MEM_WAIT share one evaluation, so a wait ends with no extra latency
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
`ifdef HAZARD_DEBUG_STEP_EN
        ret_halt_d = ret_halt_q;
`endif
        case (state_q)
            S_RUN, S_MEM_WAIT: begin
                if (hs.mem_busy) begin
                    state_d = S_MEM_WAIT;
                end else if (hs.ex_pc_write) begin
                    fcnt_d  = FLUSH_LOAD;
                    state_d = (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;
`ifdef HAZARD_DEBUG_STEP_EN
                    ret_halt_d = 1'b0;
`endif
                end else if (lu) begin
                    state_d = S_RUN;
`ifdef HAZARD_DEBUG_STEP_EN
                end else if (hs.dbg_halt) begin
                    state_d = S_HALT;
`endif
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (!hs.mem_busy) begin
                    fcnt_d = fcnt_q - 2'd1;
                    if (fcnt_q <= 2'd1) begin
                        fcnt_d = 2'd0;
`ifdef HAZARD_DEBUG_STEP_EN
                        state_d = ret_halt_q ? S_HALT : S_RUN;
`else
                        state_d = S_RUN;
`endif
                    end
                end
            end
`ifdef HAZARD_DEBUG_STEP_EN
            S_HALT: begin
                if (!hs.dbg_halt) begin
                    state_d = S_RUN;
                end else if (hs.dbg_step) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (hs.ex_pc_write) begin
                    fcnt_d     = FLUSH_LOAD;
                    ret_halt_d = 1'b1;
                    state_d    = (FLUSH_CYCLES == 1) ? S_HALT : S_FLUSH;
                end else begin
                    state_d = S_HALT;
                end
            end
`endif
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        stall_c = 1'b0;
        flush_c = 1'b0;
`ifdef HAZARD_DEBUG_STEP_EN
        halted_c = 1'b0;
`endif
        case (state_q)
            S_RUN, S_MEM_WAIT: begin
                if (hs.mem_busy) begin
                    stall_c = 1'b1;
                end else if (hs.ex_pc_write) begin
                    flush_c = 1'b1;
                end else if (lu) begin
                    stall_c = 1'b1;
                end
            end
            S_FLUSH: begin
                if (hs.mem_busy) begin
                    stall_c = 1'b1;
                end else begin
                    flush_c = 1'b1;
                end
`ifdef HAZARD_DEBUG_STEP_EN
                halted_c = ret_halt_q;
`endif
            end
`ifdef HAZARD_DEBUG_STEP_EN
            S_HALT: begin
                stall_c  = 1'b1;
                halted_c = 1'b1;
            end
            S_STEP: begin
                halted_c = 1'b1;
                if (hs.ex_pc_write) begin
                    flush_c = 1'b1;
                end else if (lu) begin
                    stall_c = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Mealy outputs are gated so nothing leaks out while reset is held
    assign pc_stall_o     = stall_c & reset;
    assign hs.pc_stall    = pc_stall_o;
    assign hs.if_id_stall = pc_stall_o;
    assign hs.hazard      = pc_stall_o;
    assign hs.flush       = flush_c & reset;
`ifdef HAZARD_DEBUG_STEP_EN
    assign hs.halted      = halted_c & reset;
`else
    assign hs.halted      = 1'b0;
`endif

    always_comb begin
        stall_count_d = stall_count_q;
        if (pc_stall_o && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    assign hs.stall_count = stall_count_q;
endmodule
